// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock qualification and core reset release, with retry on timeout, loss or relock.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       ext_relock,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] timeout_count,
  output logic [7:0] loss_count
);
  localparam int MAB = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MX  = MAB > LOCK_TIMEOUT_CYCLES ? MAB : LOCK_TIMEOUT_CYCLES;
  localparam int CW  = $clog2(MX) + 1;
  typedef enum logic [1:0] {PLLRST, WAIT_LOCK, STABLE, RUN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic sync1, locked_s, to_inc, loss_inc;
  always_ff @(posedge refclk) {locked_s, sync1} <= {sync1, pll_locked};
  always_comb begin
    nxt = state;
    cnt_n = cnt + 1'b1;
    to_inc = 1'b0;
    loss_inc = 1'b0;
    case (state)
      PLLRST:
        if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
          nxt = WAIT_LOCK;
          cnt_n = '0;
        end
      WAIT_LOCK:
        if (ext_relock) begin
          nxt = PLLRST;
          cnt_n = '0;
        end else if (locked_s) begin
          nxt = STABLE;
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          nxt = PLLRST;
          cnt_n = '0;
          to_inc = 1'b1;
        end
      STABLE:
        if (ext_relock) begin
          nxt = PLLRST;
          cnt_n = '0;
        end else if (!locked_s) begin
          nxt = WAIT_LOCK;
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          nxt = RUN;
          cnt_n = '0;
        end
      RUN: begin
        cnt_n = '0;
        nxt = (!locked_s || ext_relock) ? PLLRST : RUN;
        loss_inc = !locked_s;
      end
      default: begin
        nxt = PLLRST;
        cnt_n = '0;
      end
    endcase
  end
  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= PLLRST;
      cnt <= '0;
      pll_rst <= 1'b1;
      core_reset <= 1'b1;
      ready <= 1'b0;
      timeout_count <= 8'd0;
      loss_count <= 8'd0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      pll_rst <= nxt == PLLRST;
      core_reset <= nxt != RUN;
      ready <= nxt == RUN;
      if (to_inc && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      if (loss_inc && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed and randomized checks against a countdown-based reference model.
module tb_pll_lock_sequencer;
  localparam int PRC = 4, STC = 8, TOC = 32;
  logic refclk = 0, rst = 1, pll_locked = 0, ext_relock = 0;
  logic pll_rst, core_reset, ready;
  logic [7:0] timeout_count, loss_count;
  int checks = 0, errors = 0;
  bit go = 0;
  pll_lock_sequencer #(.PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(STC), .LOCK_TIMEOUT_CYCLES(TOC)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .ext_relock(ext_relock),
    .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready),
    .timeout_count(timeout_count), .loss_count(loss_count));
  always #5 refclk = ~refclk;
  // Reference: phase 0 reset pulse, 1 waiting, 2 qualifying, 3 running; 'left' = edges remaining in phase.
  int ph = 0, left = PRC, m_tc = 0, m_lc = 0;
  bit h1 = 0, h2 = 0;
  always @(posedge refclk) begin
    bit ls;
    ls = h2;
    h2 = h1;
    h1 = pll_locked;
    if (rst) begin
      ph = 0; left = PRC; m_tc = 0; m_lc = 0;
    end else if (ph == 0) begin
      left = left - 1;
      if (left == 0) begin ph = 1; left = TOC; end
    end else if (ph == 3 && !ls) begin
      m_lc = m_lc < 255 ? m_lc + 1 : 255; ph = 0; left = PRC;
    end else if (ext_relock) begin
      ph = 0; left = PRC;
    end else if (ph == 1) begin
      if (ls) begin ph = 2; left = STC; end
      else begin
        left = left - 1;
        if (left == 0) begin m_tc = m_tc < 255 ? m_tc + 1 : 255; ph = 0; left = PRC; end
      end
    end else if (ph == 2) begin
      if (!ls) begin ph = 1; left = TOC; end
      else begin left = left - 1; if (left == 0) ph = 3; end
    end
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge refclk) if (go) begin
    chk("pll_rst", pll_rst, ph == 0);
    chk("ready", ready, ph == 3);
    chk("core_reset", core_reset, ph != 3);
    chk("timeout_count", timeout_count, m_tc);
    chk("loss_count", loss_count, m_lc);
  end
  task automatic tick(int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask
  task automatic chk_reset(string nm);
    chk({nm, "_pll_rst"}, pll_rst, 1);
    chk({nm, "_core_reset"}, core_reset, 1);
    chk({nm, "_ready"}, ready, 0);
    chk({nm, "_tc"}, timeout_count, 0);
    chk({nm, "_lc"}, loss_count, 0);
  endtask
  task automatic wait_ready(string nm);
    int n = 0;
    while (!ready && n < 200) begin tick(1); n++; end
    chk({nm, "_reached_run"}, ready, 1);
  endtask
  initial begin
    int first, k;
    tick(3);
    go = 1;
    chk_reset("reset");
    rst = 0;
    tick(3);
    chk("t1_pll_rst_e3", pll_rst, 1);
    tick(1);
    chk("t1_pll_rst_e4", pll_rst, 0);
    chk("t1_ready", ready, 0);
    pll_locked = 1;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (ready && first == 0) first = n;
    end
    chk("t2_edges_to_ready", first, 11);
    chk("t2_counts", timeout_count + loss_count, 0);
    pll_locked = 0;
    tick(2);
    chk("t4_ready_e2", ready, 1);
    tick(1);
    chk("t4_ready_e3", ready, 0);
    chk("t4_pll_rst_e3", pll_rst, 1);
    chk("t4_loss", loss_count, 1);
    pll_locked = 1;
    wait_ready("t4");
    ext_relock = 1;
    tick(1);
    ext_relock = 0;
    chk("t5_relock_pll_rst", pll_rst, 1);
    k = 0;
    while (pll_rst && k < 50) begin tick(1); k++; end
    chk("t5_wait_entered", pll_rst, 0);
    tick(4);
    pll_locked = 0;
    tick(1);
    pll_locked = 1;
    k = 5;
    first = 0;
    while (first == 0 && k < 40) begin
      tick(1); k++;
      if (ready) first = k;
    end
    chk("t5_glitch_ready_edge", first, 16);
    chk("t5_loss_unchanged", loss_count, 1);
    pll_locked = 0;
    tick(3);
    chk("t3_loss", loss_count, 2);
    tick(35);
    chk("t3_tc_before", timeout_count, 0);
    tick(1);
    chk("t3_tc_first", timeout_count, 1);
    chk("t3_pll_rst_retry", pll_rst, 1);
    tick(36 * 300);
    chk("t3_tc_saturated", timeout_count, 255);
    pll_locked = 1;
    k = 0;
    while (pll_rst && k < 50) begin tick(1); k++; end
    tick(3);
    rst = 1;
    tick(1);
    chk_reset("t6_stable");
    rst = 0;
    tick(2);
    rst = 1;
    tick(1);
    chk_reset("t6_pllrst");
    rst = 0;
    for (int i = 0; i < 20000; i++) begin
      ext_relock = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 1999) == 0;
      if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
      tick(1);
    end
    rst = 0;
    ext_relock = 0;
    tick(2);
    go = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
